// File: rtl/ws2812_streamer.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_streamer
// Purpose  : Streams one frame of RGB565 pixels from a frame-buffer RAM to a
//            WS2812 LED chain. Each pixel is expanded to 24-bit GRB and sent
//            MSB first. The next pixel is prefetched so that bits stay
//            back-to-back across pixel boundaries. A low latch period follows
//            the last pixel.
// Ports    : clk      - clock, rising edge
//            resetn   - asynchronous active-low reset
//            start    - one-cycle frame request, honoured only in IDLE
//            busy     - high from the cycle after an accepted start until done
//            done     - one-cycle pulse at the end of the latch period
//            adb/ceb  - frame-buffer read address / enable (1-cycle latency)
//            doutb    - frame-buffer read data, RGB565
//            led_dout - WS2812 serial data line
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_streamer #(
  parameter int NUM_PIXELS = 256,
  parameter int BASE_ADDR  = 0,
  parameter int T0H        = 20,
  parameter int T0L        = 42,
  parameter int T1H        = 40,
  parameter int T1L        = 22,
  parameter int RST_CYCLES = 16000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [11:0] adb,
  output logic        ceb,
  input  logic [15:0] doutb,
  output logic        led_dout
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (T0H + T0L != T1H + T1L) begin : g_err_period
    $error("ws2812_streamer: T0H+T0L must equal T1H+T1L");
  end
  if (T0H < 2 || T0L < 2 || T1H < 2 || T1L < 2 || RST_CYCLES < 2) begin : g_err_min
    $error("ws2812_streamer: all timing parameters must be at least 2");
  end
  if (NUM_PIXELS < 1 || NUM_PIXELS > 4096) begin : g_err_npix
    $error("ws2812_streamer: NUM_PIXELS must be in 1..4096");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_HIGH  = 3'd3;
  localparam logic [2:0] c_LOW   = 3'd4;
  localparam logic [2:0] c_LATCH = 3'd5;

  localparam int c_TMAX_0 = (T0H > T0L) ? T0H : T0L;
  localparam int c_TMAX_1 = (T1H > T1L) ? T1H : T1L;
  localparam int c_TMAX_B = (c_TMAX_0 > c_TMAX_1) ? c_TMAX_0 : c_TMAX_1;
  localparam int c_TMAX   = (c_TMAX_B > RST_CYCLES) ? c_TMAX_B : RST_CYCLES;
  // Timer counts 0..(duration-1), so clog2 of the longest duration suffices.
  localparam int c_TW     = $clog2(c_TMAX);
  localparam int c_IW     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  localparam logic [c_TW-1:0] c_T0H_END = c_TW'(T0H - 1);
  localparam logic [c_TW-1:0] c_T0L_END = c_TW'(T0L - 1);
  localparam logic [c_TW-1:0] c_T1H_END = c_TW'(T1H - 1);
  localparam logic [c_TW-1:0] c_T1L_END = c_TW'(T1L - 1);
  localparam logic [c_TW-1:0] c_RST_END = c_TW'(RST_CYCLES - 1);

  localparam logic [11:0]     c_BASE     = 12'(BASE_ADDR);
  localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(NUM_PIXELS - 1);

  // RGB565 -> GRB888; the top bits are replicated into the low bits so that
  // full-scale inputs map to full-scale outputs.
  function automatic logic [23:0] rgb565_to_grb(input logic [15:0] p);
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
    r8 = {p[15:11], p[15:13]};
    g8 = {p[10:5],  p[10:9]};
    b8 = {p[4:0],   p[4:2]};
    return {g8, r8, b8};
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]      state_q, state_d;
  logic [c_TW-1:0] tcnt_q,  tcnt_d;
  logic [4:0]      bit_q,   bit_d;
  logic [c_IW-1:0] idx_q,   idx_d;
  logic [23:0]     shift_q, shift_d;
  logic [23:0]     hold_q,  hold_d;
  logic            pf_q,    pf_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;

  logic            w_cur_bit;
  logic            w_high_end;
  logic            w_low_end;
  logic            w_last_pix;
  logic            w_prefetch;
  logic [11:0]     w_addr_cur;
  logic [11:0]     w_addr_next;

  assign w_cur_bit   = shift_q[23];
  assign w_high_end  = (tcnt_q == (w_cur_bit ? c_T1H_END : c_T0H_END));
  assign w_low_end   = (tcnt_q == (w_cur_bit ? c_T1L_END : c_T0L_END));
  assign w_last_pix  = (idx_q == c_LAST_IDX);
  // Prefetch fires on the first HIGH cycle of the last bit of a pixel; the
  // read data lands while that HIGH phase is still in progress.
  assign w_prefetch  = (state_q == c_HIGH) && (bit_q == 5'd23) &&
                       (tcnt_q == '0) && !w_last_pix;
  assign w_addr_cur  = c_BASE + 12'(idx_q);
  assign w_addr_next = w_addr_cur + 12'd1;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pf_d    = w_prefetch;

    if (pf_q) begin
      hold_d = rgb565_to_grb(doutb);
    end

    case (state_q)
      c_IDLE: begin
        // A start coinciding with the done pulse is deliberately dropped.
        if (start && !done_q) begin
          idx_d   = '0;
          tcnt_d  = '0;
          busy_d  = 1'b1;
          state_d = c_FETCH;
        end
      end
      c_FETCH: begin
        tcnt_d  = '0;
        state_d = c_WAIT;
      end
      c_WAIT: begin
        shift_d = rgb565_to_grb(doutb);
        bit_d   = '0;
        tcnt_d  = '0;
        state_d = c_HIGH;
      end
      c_HIGH: begin
        if (w_high_end) begin
          tcnt_d  = '0;
          state_d = c_LOW;
        end else begin
          tcnt_d  = tcnt_q + c_TW'(1);
        end
      end
      c_LOW: begin
        if (w_low_end) begin
          tcnt_d = '0;
          if (bit_q == 5'd23) begin
            if (w_last_pix) begin
              state_d = c_LATCH;
            end else begin
              shift_d = hold_q;
              bit_d   = '0;
              idx_d   = idx_q + c_IW'(1);
              state_d = c_HIGH;
            end
          end else begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q + 5'd1;
            state_d = c_HIGH;
          end
        end else begin
          tcnt_d = tcnt_q + c_TW'(1);
        end
      end
      c_LATCH: begin
        if (tcnt_q == c_RST_END) begin
          tcnt_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = c_IDLE;
        end else begin
          tcnt_d  = tcnt_q + c_TW'(1);
        end
      end
      default: begin
        tcnt_d  = '0;
        busy_d  = 1'b0;
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= c_IDLE;
      tcnt_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      pf_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      pf_q    <= pf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded straight from state so the asynchronous reset drops the
  // line immediately rather than finishing a partial bit.
  // --------------------------------------------------------------------------
  assign led_dout = (state_q == c_HIGH);
  assign ceb      = (state_q == c_FETCH) || w_prefetch;
  assign adb      = (state_q == c_FETCH) ? w_addr_cur  :
                    w_prefetch           ? w_addr_next : 12'd0;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_streamer
// Purpose  : Directed self-checking bench for ws2812_streamer. Three
//            instances cover a single-pixel frame, a three-pixel frame at a
//            non-zero base, and an address wrap at 4095. Pixel words are
//            decoded from the sampled serial waveform and compared against
//            hand-expanded GRB values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_streamer;

  logic        clk;
  logic        resetn;
  logic        start;
  int          sel;

  logic        start_a, start_b, start_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [11:0] adb_a, adb_b, adb_c;
  logic        ceb_a, ceb_b, ceb_c;
  logic [15:0] doutb_a, doutb_b, doutb_c;
  logic        led_a, led_b, led_c;

  logic [15:0] mem [0:4095];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          busy_cnt;
  bit          wave [$];
  logic [11:0] rd   [$];

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  logic        w_led, w_busy, w_done, w_ceb;
  logic [11:0] w_adb;
  assign w_led  = (sel == 0) ? led_a  : (sel == 1) ? led_b  : led_c;
  assign w_busy = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign w_done = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  assign w_ceb  = (sel == 0) ? ceb_a  : (sel == 1) ? ceb_b  : ceb_c;
  assign w_adb  = (sel == 0) ? adb_a  : (sel == 1) ? adb_b  : adb_c;

  ws2812_streamer #(.NUM_PIXELS(1), .BASE_ADDR(0), .T0H(2), .T0L(4), .T1H(4), .T1L(2), .RST_CYCLES(10))
  u_a (.clk(clk), .resetn(resetn), .start(start_a), .busy(busy_a), .done(done_a),
       .adb(adb_a), .ceb(ceb_a), .doutb(doutb_a), .led_dout(led_a));

  ws2812_streamer #(.NUM_PIXELS(3), .BASE_ADDR(16), .T0H(2), .T0L(4), .T1H(4), .T1L(2), .RST_CYCLES(10))
  u_b (.clk(clk), .resetn(resetn), .start(start_b), .busy(busy_b), .done(done_b),
       .adb(adb_b), .ceb(ceb_b), .doutb(doutb_b), .led_dout(led_b));

  ws2812_streamer #(.NUM_PIXELS(2), .BASE_ADDR(4095), .T0H(2), .T0L(4), .T1H(4), .T1L(2), .RST_CYCLES(10))
  u_c (.clk(clk), .resetn(resetn), .start(start_c), .busy(busy_c), .done(done_c),
       .adb(adb_c), .ceb(ceb_c), .doutb(doutb_c), .led_dout(led_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1-cycle-latency RAM; garbage when not enabled so mistimed captures show.
  always @(posedge clk) begin
    doutb_a <= ceb_a ? mem[adb_a] : 16'hDEAD;
    doutb_b <= ceb_b ? mem[adb_b] : 16'hDEAD;
    doutb_c <= ceb_c ? mem[adb_c] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples from the FETCH cycle until done is seen; returns at the negedge
  // inside the done cycle. storm=1 pulses start repeatedly while busy.
  task automatic capture(input bit storm);
    int n;
    n = 0;
    wave.delete();
    rd.delete();
    busy_cnt = 0;
    while (w_done !== 1'b1 && n < 20000) begin
      wave.push_back(w_led);
      if (w_busy) busy_cnt++;
      if (w_ceb) rd.push_back(w_adb);
      start = storm && (n % 7 == 3);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_within_budget", 32'(n < 20000), 32'd1);
  endtask

  task automatic verify(input string tag, input int np,
                        input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2,
                        input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2);
    int          need;
    int          bad;
    int          ones;
    logic [23:0] exp_pix [3];
    logic [11:0] exp_adr [3];
    logic [23:0] v;
    logic [5:0]  w;
    exp_pix[0] = e0; exp_pix[1] = e1; exp_pix[2] = e2;
    exp_adr[0] = a0; exp_adr[1] = a1; exp_adr[2] = a2;
    need = 2 + 144 * np + 10;
    check({tag, "_frame_len"},    32'(wave.size()), 32'(need));
    check({tag, "_busy_cycles"},  32'(busy_cnt),    32'(need));
    check({tag, "_busy_at_done"}, 32'(w_busy),      32'd0);
    while (wave.size() < need) wave.push_back(1'b0);
    bad = 0;
    for (int p = 0; p < np; p++) begin
      v = '0;
      for (int b = 0; b < 24; b++) begin
        for (int k = 0; k < 6; k++) w[5-k] = wave[2 + (p * 24 + b) * 6 + k];
        if (w != 6'b110000 && w != 6'b111100) bad++;
        v = {v[22:0], (w == 6'b111100)};
      end
      check($sformatf("%s_pixel%0d_grb", tag, p), 32'(v), 32'(exp_pix[p]));
    end
    check({tag, "_bad_bit_windows"}, 32'(bad), 32'd0);
    ones = 0;
    for (int i = 0; i < 2; i++) ones += int'(wave[i]);
    for (int i = 2 + 144 * np; i < need; i++) ones += int'(wave[i]);
    check({tag, "_idle_and_latch_low"}, 32'(ones), 32'd0);
    check({tag, "_read_count"}, 32'(rd.size()), 32'(np));
    for (int i = 0; i < np && i < rd.size(); i++)
      check($sformatf("%s_read%0d_addr", tag, i), 32'(rd[i]), 32'(exp_adr[i]));
  endtask

  initial begin
    int errs;
    resetn = 1'b0;
    start  = 1'b0;
    sel    = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

    // Reset state of all three instances
    repeat (3) @(negedge clk);
    check("reset_a", 32'({led_a, busy_a, done_a, ceb_a, adb_a}), 32'd0);
    check("reset_b", 32'({led_b, busy_b, done_b, ceb_b, adb_b}), 32'd0);
    check("reset_c", 32'({led_c, busy_c, done_c, ceb_c, adb_c}), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 32'({led_a, busy_a, ceb_a, led_b, busy_b, ceb_b}), 32'd0);

    // Single pixel, pure red -> GRB 0x00FF00
    sel = 0;
    mem[0] = 16'hF800;
    pulse_start();
    capture(1'b0);
    verify("one_px", 1, 24'h00FF00, 24'h0, 24'h0, 12'h000, 12'h000, 12'h000);
    @(negedge clk);
    check("done_single_pulse", 32'(w_done), 32'd0);

    // Three pixels at base 0x010, prefetch across boundaries
    sel = 1;
    mem[16] = 16'h07E0;
    mem[17] = 16'h001F;
    mem[18] = 16'hFFFF;
    pulse_start();
    capture(1'b0);
    verify("three_px", 3, 24'hFF0000, 24'h0000FF, 24'hFFFFFF, 12'h010, 12'h011, 12'h012);

    // Address wrap 0xFFF -> 0x000; low-bit replication of 0x0841
    sel = 2;
    mem[4095] = 16'h0841;
    mem[0]    = 16'hF800;
    pulse_start();
    capture(1'b0);
    verify("wrap", 2, 24'h080808, 24'h00FF00, 24'h0, 12'hFFF, 12'h000, 12'h000);

    // Start storm while busy, start in the done cycle, start one cycle later
    sel = 0;
    mem[0] = 16'h07E0;
    pulse_start();
    capture(1'b1);
    verify("storm", 1, 24'hFF0000, 24'h0, 24'h0, 12'h000, 12'h000, 12'h000);
    start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", 32'(w_busy), 32'd0);
    check("no_read_after_done",    32'(w_ceb),  32'd0);
    @(negedge clk);
    start = 1'b0;
    check("start_after_done_accepted", 32'(w_busy), 32'd1);
    capture(1'b0);
    verify("restart", 1, 24'hFF0000, 24'h0, 24'h0, 12'h000, 12'h000, 12'h000);

    // Reset during bit 5 of pixel 1 (first HIGH cycle of that bit)
    sel = 1;
    pulse_start();
    repeat (176) @(negedge clk);
    check("pre_reset_line_high", 32'(w_led), 32'd1);
    resetn = 1'b0;
    #1;
    check("reset_led_low_async",  32'(w_led),  32'd0);
    check("reset_busy_low_async", 32'(w_busy), 32'd0);
    errs = 0;
    repeat (3) begin
      @(negedge clk);
      if (w_done || w_busy || w_led || w_ceb) errs++;
    end
    resetn = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (w_done || w_busy || w_led || w_ceb) errs++;
    end
    check("idle_after_midframe_reset", 32'(errs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ws2812_streamer.md
WS2812_STREAMER -- requirements
Module: ws2812_streamer

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- NUM_PIXELS, 256, pixels per frame; legal range 1..4096.
- BASE_ADDR, 0, RAM word address of pixel 0.
- T0H, 20, cycles high for a 0 bit.
- T0L, 42, cycles low for a 0 bit.
- T1H, 40, cycles high for a 1 bit.
- T1L, 22, cycles low for a 1 bit.
- RST_CYCLES, 16000, latch low time after a frame.
REQ-002 T0H+T0L SHALL equal T1H+T1L, and all timing parameters SHALL be at least 2; violating either is an elaboration error.
REQ-003 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1, single clock; rising edge.
- resetn, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to send one frame.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse at the end of the latch period.
- adb, out, 12, frame-buffer read address (RAM port B).
- ceb, out, 1, frame-buffer read enable.
- doutb, in, 16, frame-buffer read data in RGB565 format ([15:11] R, [10:5] G, [4:0] B).
- led_dout, out, 1, WS2812 serial data line.
REQ-004 Frame-buffer read latency SHALL be 1 cycle: doutb is valid in the cycle after the cycle in which ceb=1 is presented with adb.

Function
REQ-005 The FSM states SHALL be IDLE, FETCH, WAIT, HIGH, LOW and LATCH.
REQ-006 In IDLE with start=1, the block SHALL load the pixel index to 0, set busy, and go to FETCH; start is ignored in every other state.
REQ-007 FETCH (1 cycle) SHALL assert ceb with adb = (BASE_ADDR + index) mod 4096, then move to WAIT.
REQ-008 WAIT (1 cycle) SHALL capture doutb and expand it into a 24-bit GRB shift register, then move to HIGH.
- G = {G6, G6[5:4]}.
- R = {R5, R5[4:2]}.
- B = {B5, B5[4:2]}.
- Transmission order: G[7] first, B[0] last.
REQ-009 HIGH SHALL drive led_dout=1 for T1H cycles if the current bit is 1, else T0H cycles; LOW SHALL drive led_dout=0 for T1L or T0L cycles respectively; LOW then advances to the next bit.
REQ-010 Consecutive bits SHALL have no idle cycles between them, so every bit period is exactly T0H+T0L cycles.
REQ-011 The next pixel SHALL be prefetched so that no gap appears between pixels:
- During the HIGH phase of bit 23 of pixel n, with n < NUM_PIXELS-1, the block asserts ceb for one cycle with the address of pixel n+1.
- It captures and expands doutb one cycle later into a holding register.
- The holding register is loaded into the shift register when pixel n's last LOW ends.
REQ-012 After the last LOW of pixel NUM_PIXELS-1, the block SHALL enter LATCH, holding led_dout=0 for RST_CYCLES cycles.
- It then pulses done for 1 cycle, clears busy in that same cycle, and returns to IDLE.
REQ-013 A start arriving in the same cycle as done SHALL be ignored; a start in the following cycle SHALL be accepted.
REQ-014 ceb SHALL be 1 only in FETCH and in the prefetch cycle, giving exactly NUM_PIXELS read strobes per frame.
REQ-015 Address arithmetic SHALL be 12-bit and wrap modulo 4096 (for example BASE_ADDR=4095 with NUM_PIXELS=2 reads 4095 and then 0).
REQ-016 The bit counter (0..23), pixel index (0..NUM_PIXELS-1) and timing counter SHALL each be sized for their maximum value, and every counter SHALL clear when its state is entered.

Reset
REQ-017 While resetn=0, the outputs SHALL be:
- led_dout=0, busy=0, done=0, ceb=0, adb=0.
- FSM in IDLE; all counters and shift registers cleared.
REQ-018 Reset assertion mid-frame SHALL force led_dout low asynchronously, with no partial-bit completion.
REQ-019 After resetn deasserts, the block SHALL require a new start before sending.

Verification
Scenarios use T0H=2, T0L=4, T1H=4, T1L=2, RST_CYCLES=10 and a RAM model with 1-cycle latency.
REQ-020 NUM_PIXELS=1, doutb=0xF800, start -> led_dout emits 8×(2 high, 4 low), 8×(4 high, 2 low), 8×(2 high, 4 low), then 10 low; done then pulses once; busy is high for 2+144+10 cycles.
REQ-021 NUM_PIXELS=3, BASE_ADDR=0x010, pixels 0x07E0, 0x001F, 0xFFFF -> reads at 0x010, 0x011, 0x012 in order; GRB stream 0xFF0000, 0x0000FF, 0xFFFFFF; 432 contiguous bit-cycles with no gap at pixel boundaries.
REQ-022 BASE_ADDR=4095, NUM_PIXELS=2 -> adb sequence 0xFFF then 0x000; exactly 2 ceb strobes.
REQ-023 start pulsed repeatedly while busy, and again in the done cycle -> no restart and no extra reads; start one cycle after done -> a new frame begins.
REQ-024 resetn pulled low during bit 5 of pixel 1 -> led_dout=0 and busy=0 immediately; no done pulse; after release the line stays idle until start.
REQ-025 doutb=0x0841 (R=1, G=2, B=1) -> GRB expands to G=0x08, R=0x08, B=0x08.
